bcd_alu_serial: RTL and testbench
=================================

Name: bcd_alu_serial

Overview:
Parametrised, digit-serial BCD add/subtract unit, successor to the fixed 3-digit combinational adder between the keypad entry logic and the display multiplexer. It processes NDIG packed-BCD digits one per clock under a start/busy/done handshake. It adds a subtract mode with a sign output, a carry/overflow output and input-digit validation. The result is registered and held for the display path until the next operation.

Parameters:
NDIG, 4, operand/result width in BCD digits (≥1); buses are 4*NDIG bits.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = add (A+B), 1 = subtract (A−B)
a_bcd  in  4*NDIG  operand A, packed BCD, digit 0 in bits [3:0]
b_bcd  in  4*NDIG  operand B, same format
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result and flags valid from this cycle
result  out  4*NDIG  packed BCD magnitude, held until the next accepted start
carry  out  1  add: carry out of the MSD (sum ≥ 10^NDIG); sub: 0
neg  out  1  sub: A < B, result = B−A; add: 0
err  out  1  an operand digit > 9 was detected at capture

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, carry, neg, err = 0; result = 0; internal shift registers and carry cleared.
- States: IDLE, ADD, FIX, DONE.
- IDLE, start=1 at cycle t:
  - capture a_bcd, b_bcd and op into shift registers.
  - If any digit of either operand is > 9: next state DONE with err=1, result=0, carry=neg=0.
  - Otherwise: next state ADD, digit counter = 0.
- ADD, one digit per cycle, LSD first:
  - add: d = a_i + b_i + c; sub: d = a_i + (9 − b_i) + c, with c initialised to op.
  - Apply BCD correction (+6 when binary sum > 9); the digit carries to the next cycle.
  - Sum digit shifts into the result register at the MSD end; operands shift right 4 bits.
  - After NDIG cycles (t+1..t+NDIG), final carry = cN.
  - add: carry=cN, next DONE.
  - sub with cN=1: neg=0, next DONE.
  - sub with cN=0: neg=1, next FIX.
- FIX, NDIG cycles (t+NDIG+1..t+2·NDIG): replace result by its ten's complement, digit-serial LSD first (0 − r_i − borrow), giving |A−B|. Next DONE.
- DONE, one cycle: done=1, busy=0. Next IDLE.
- Latency, start → done:
  - invalid operand: 1 cycle.
  - add, or sub with non-negative result: NDIG+1 cycles.
  - negative sub: 2·NDIG+1 cycles.
- busy=1 in ADD and FIX only.
- start while not in IDLE (ADD/FIX/DONE) is ignored; no queuing.
- Operand inputs may change after capture without effect.
- Equal operands under sub: result=0, neg=0 (end carry is 1).
- Add with carry=1: result holds the low NDIG digits (wrap modulo 10^NDIG).
- Outputs result, carry, neg and err update only on transition into DONE. They hold through IDLE, so the display stays stable during the next computation.
- Reset asserted mid-operation aborts the operation; no done pulse.

Decomposition:
- Package bcd_pkg:
  - state enum (IDLE, ADD, FIX, DONE).
  - op encoding constants OP_ADD=0, OP_SUB=1.
  - BCD_MAX=9 and BCD_ADJ=6.
  - function is_bcd_digit(nibble).
- One sub-module, bcd_digit_adder: combinational single-digit adder, (a[3:0], b[3:0], cin) → (sum[3:0], cout) with +6 correction. Instantiated once and shared by ADD and FIX (FIX feeds a=0, b=9−r_i, cin).

Test Plan:
1. NDIG=4, op=0, A=0999, B=0001, start at t → done at t+5, result=1000, carry=0, neg=0, err=0.
2. op=0, A=9999, B=0001 → result=0000, carry=1, done at t+5.
3. op=1, A=0500, B=0123 → result=0377, neg=0, done at t+5; then A=B=4321 → result=0000, neg=0.
4. op=1, A=0123, B=0500 → result=0377, neg=1, busy high t+1..t+8, done at t+9.
5. A=00A1 (digit 1 = 0xA), B=0000 → err=1, result=0000, done at t+1, busy never high.
6. Start accepted, assert rst at t+2 → busy=0, result=0, no done. Also pulse start during ADD of a valid op → ignored, original result delivered at the original done cycle.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the digit-serial BCD add/subtract unit
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit_adder.sv
// bcd_digit_adder: single BCD digit adder with +6 decimal correction
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] bin;
  assign bin  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign cout = bin > {1'b0, BCD_MAX};
  assign sum  = cout ? 4'(bin + {1'b0, BCD_ADJ}) : bin[3:0];
endmodule

// File: rtl/bcd_alu_serial.sv
// bcd_alu_serial: digit-serial packed-BCD add/subtract with sign, carry and digit validation
module bcd_alu_serial
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] result,
  output logic              carry,
  output logic              neg,
  output logic              err
);
  localparam int W  = 4 * NDIG;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  state_t state, state_nx;
  logic [W-1:0] a_sh, b_sh, acc, acc_nx;
  logic [CW-1:0] cnt;
  logic op_r, c, valid, last, fix_needed;
  logic [3:0] da, db, ds;
  logic dc;
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < NDIG; i++)
      valid = valid & is_bcd_digit(a_bcd[4*i+:4]) & is_bcd_digit(b_bcd[4*i+:4]);
  end
  assign last = cnt == CW'(NDIG - 1);
  // FIX reuses the adder as 0 + (9 - r_i) + borrow-chain to form the ten's complement
  assign da = state == FIX ? 4'd0 : a_sh[3:0];
  assign db = state == FIX ? BCD_MAX - acc[3:0] :
              op_r == OP_SUB ? BCD_MAX - b_sh[3:0] : b_sh[3:0];
  assign acc_nx = W'({ds, acc} >> 4);
  assign fix_needed = op_r == OP_SUB && !dc;
  bcd_digit_adder u_add (.a(da), .b(db), .cin(c), .sum(ds), .cout(dc));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = valid ? ADD : DONE;
      ADD:     if (last) state_nx = fix_needed ? FIX : DONE;
      FIX:     if (last) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy = state == ADD || state == FIX;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_r   <= 1'b0;
      c      <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh <= a_bcd;
          b_sh <= b_bcd;
          op_r <= op;
          c    <= op;
          cnt  <= '0;
          acc  <= '0;
          if (!valid) begin
            result <= '0;
            carry  <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b1;
          end
        end
        ADD: begin
          a_sh <= a_sh >> 4;
          b_sh <= b_sh >> 4;
          acc  <= acc_nx;
          cnt  <= last ? '0 : cnt + 1'b1;
          c    <= last && fix_needed ? 1'b1 : dc;
          if (last && !fix_needed) begin
            result <= acc_nx;
            carry  <= op_r == OP_ADD && dc;
            neg    <= 1'b0;
            err    <= 1'b0;
          end
        end
        FIX: begin
          acc <= acc_nx;
          cnt <= last ? '0 : cnt + 1'b1;
          c   <= dc;
          if (last) begin
            result <= acc_nx;
            carry  <= 1'b0;
            neg    <= 1'b1;
            err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_alu_serial.sv
// tb_bcd_alu_serial: directed checks of latency, handshake, result and flags for NDIG=4
module tb_bcd_alu_serial;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op = 1'b0;
  logic [15:0] a_bcd = '0, b_bcd = '0;
  logic busy, done, carry, neg, err;
  logic [15:0] result;
  logic [15:0] prev_res = '0;
  int n_asrt = 0, n_fail = 0;
  bcd_alu_serial #(.NDIG(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_bcd(a_bcd), .b_bcd(b_bcd),
    .busy(busy), .done(done), .result(result), .carry(carry), .neg(neg), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic o, input logic [15:0] a, input logic [15:0] b,
                     input int lat, input logic [15:0] er, input logic ec, input logic en,
                     input logic ee, input bit poke);
    @(negedge clk);
    op = o; a_bcd = a; b_bcd = b; start = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; a_bcd = 16'hFFFF; b_bcd = 16'hFFFF; op = ~o;
        if (lat > 1) chk({tag, " held"}, result, prev_res);
      end
      if (poke && k == 2) begin start = 1'b1; a_bcd = 16'h1111; b_bcd = 16'h2222; end
      if (poke && k == 3) start = 1'b0;
      chk({tag, " busy"}, busy, 16'(k < lat));
      chk({tag, " done"}, done, 16'(k == lat));
    end
    chk({tag, " result"}, result, er);
    chk({tag, " carry"}, carry, 16'(ec));
    chk({tag, " neg"}, neg, 16'(en));
    chk({tag, " err"}, err, 16'(ee));
    prev_res = er;
    @(negedge clk);
    chk({tag, " idle"}, done, 16'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 16'd0);
    chk("rst done", done, 16'd0);
    chk("rst result", result, 16'd0);
    chk("rst flags", {carry, neg, err}, 16'd0);
    rst = 1'b0;
    run("add0999", 1'b0, 16'h0999, 16'h0001, 5, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    run("add9999", 1'b0, 16'h9999, 16'h0001, 5, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run("add4567", 1'b0, 16'h4567, 16'h5678, 5, 16'h0245, 1'b1, 1'b0, 1'b0, 1'b0);
    run("sub0500", 1'b1, 16'h0500, 16'h0123, 5, 16'h0377, 1'b0, 1'b0, 1'b0, 1'b0);
    run("subeq", 1'b1, 16'h4321, 16'h4321, 5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run("subneg", 1'b1, 16'h0123, 16'h0500, 9, 16'h0377, 1'b0, 1'b1, 1'b0, 1'b0);
    run("sub0-1", 1'b1, 16'h0000, 16'h0001, 9, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    run("sub9999", 1'b1, 16'h9999, 16'h0000, 5, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0);
    run("erra", 1'b0, 16'h00A1, 16'h0000, 1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run("add1234", 1'b0, 16'h1234, 16'h4321, 5, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0);
    run("errb", 1'b1, 16'h1234, 16'hF000, 1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run("poke", 1'b0, 16'h1234, 16'h4321, 5, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    op = 1'b1; a_bcd = 16'h0123; b_bcd = 16'h0500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort busy1", busy, 16'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort busy", busy, 16'd0);
    chk("abort result", result, 16'd0);
    chk("abort done", done, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("abort nodone", {busy, done}, 16'd0);
    end
    chk("abort flags", {carry, neg, err}, 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
